conv_5ks_ctrl: RTL and testbench
================================

# conv_5ks_ctrl

Sequencer for the 5×5, three-output-channel convolution stage (28×28 8-bit input, 24×24 output per channel). On `start` it resets the convolution datapath and streams 25 packed weight words, 3 biases and 784 pixels into it, each read from synchronous on-chip memories. It then counts the 576 valid output beats, tagging each with its row and column for the pooling stage downstream. It sits between the layer-level scheduler and the convolution datapath.

## Interface
Parameters:
- `WIDTH`, 28, input image width.
- `HEIGHT`, 28, input image height.
- `KS`, 5, kernel size; output dims are `WIDTH-KS+1` × `HEIGHT-KS+1`.
- `DATA_BIT`, 8, pixel width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle request to run one image; ignored unless idle.
- `busy`  out  1  high from the cycle after accepted `start` until the cycle `done` pulses.
- `done`  out  1  one-cycle pulse after the last output beat.
- `w_addr`  out  5  weight ROM address, 0..24.
- `w_data`  in  12  ROM word `{w3,w2,w1}`; 4 bits each; valid 1 cycle after `w_addr`.
- `b_addr`  out  2  bias ROM address, 0..2.
- `b_data`  in  8  valid 1 cycle after `b_addr`.
- `img_addr`  out  10  image RAM address, 0..783, raster order.
- `img_data`  in  DATA_BIT  valid 1 cycle after `img_addr`.
- `conv_rst`  out  1  datapath reset.
- `in_data`  out  DATA_BIT  pixel to the datapath.
- `in_weight_1/2/3`  out  4 each  weights to the datapath.
- `in_bias`  out  8  bias to the datapath.
- `conv_valid`  in  1  datapath output-valid.
- `out_valid`  out  1  registered copy of `conv_valid` while counting.
- `out_row`, `out_col`  out  5 each  coordinate of the current output beat.
- `err`  out  1  sticky timeout flag (see Configuration).

## Operation
States:
- IDLE: `conv_rst`=1, all address and data outputs 0. When `start`=1, go to LOAD_W and clear the counters.
- LOAD_W: issue `w_addr` 0..24, one per cycle. After 24, go to LOAD_B.
- LOAD_B: issue `b_addr` 0..2. After 2, go to STREAM.
- STREAM: issue `img_addr` 0..783. After 783, go to DRAIN.
- DRAIN: wait until the output counter reaches 576, then go to DONE.
- DONE: one cycle; `done`=1; go to IDLE.

Data path rules:
- Read data is registered once. Bus outputs therefore carry the word addressed two cycles earlier.
- Outside its own phase, each bus holds 0.
- `conv_rst` falls on the first cycle valid weight data appears on the weight bus. It stays low until IDLE.

Output counting:
- Counting is active in STREAM and DRAIN.
- Each `conv_valid`=1 raises `out_valid` the next cycle with the current `{out_row,out_col}`, then advances the column.
- Column wraps 23→0 and increments the row.
- `conv_valid` beats beyond 576 are ignored (`out_valid` stays 0).

Other rules:
- `start` while `busy` is ignored and has no side effects.
- `rst` mid-run forces IDLE immediately and clears all counters, outputs and `err`.

## Timing
- Reset values: `busy`, `done`, `out_valid`, `err`, all addresses and data outputs = 0; `conv_rst` = 1.
- `start` sampled at edge T: `w_addr`=0 at T+1, `in_weight_*` = word 0 at T+3, `conv_rst` low from T+3.
- Phase lengths: weights 25 cycles, biases 3, pixels 784, with no gaps between phases on the output bus.
- `out_valid` lags `conv_valid` by exactly 1 cycle.
- `done` asserts the cycle after the 576th `out_valid`. `busy` drops in the same cycle.
- Throughput: one pixel per clock, with no back-pressure.

## Configuration
- `CONV_CTRL_TIMEOUT_EN` defined:
  - A 12-bit watchdog in DRAIN counts cycles since the last `conv_valid`.
  - At 4095 it sets `err`, which is sticky until `rst` or the next accepted `start`, and forces DONE.
- Undefined:
  - There is no watchdog, and `err` is tied to 0.
  - DRAIN waits indefinitely.

## Test plan
- Reset mid-STREAM at `img_addr`=300 → next cycle: IDLE, `conv_rst`=1, `busy`=0, all addresses 0.
- Nominal run with ROM word k = `{k[3:0],k[3:0],k[3:0]}` and pixel = addr[7:0], with a model that asserts `conv_valid` for 576 cycles → `in_weight_1` sequence 0..15,0..8 starting at T+3; `in_bias` = b0,b1,b2; 784 pixels contiguous; exactly 576 `out_valid`; last beat (23,23); `done` once.
- `start` re-pulsed during LOAD_B and DRAIN → no change to addresses or counters, single `done`.
- Model sends 600 `conv_valid` beats → only 576 `out_valid`, with coordinates wrapping (0,23)→(1,0).
- With `CONV_CTRL_TIMEOUT_EN`, model stops `conv_valid` after 100 beats → `err`=1 and `done` 4095 cycles after the last beat. Without the macro → `busy` stays high and `err`=0.
- Back-to-back runs: `start` in the cycle after `done` → second run identical to the first; `err` cleared.

Source files
------------

// File: rtl/conv_5ks_ctrl_if.sv
// Bus bundle between conv_5ks_ctrl, its ROM/RAM read ports, the
// convolution datapath and the layer scheduler.
interface conv_5ks_ctrl_if #(
    parameter int DATA_BIT = 8
);
    logic                start;
    logic                busy;
    logic                done;
    logic [4:0]          w_addr;
    logic [11:0]         w_data;
    logic [1:0]          b_addr;
    logic [7:0]          b_data;
    logic [9:0]          img_addr;
    logic [DATA_BIT-1:0] img_data;
    logic                conv_rst;
    logic [DATA_BIT-1:0] in_data;
    logic [3:0]          in_weight_1;
    logic [3:0]          in_weight_2;
    logic [3:0]          in_weight_3;
    logic [7:0]          in_bias;
    logic                conv_valid;
    logic                out_valid;
    logic [4:0]          out_row;
    logic [4:0]          out_col;
    logic                err;

    modport master (
        input  start, w_data, b_data, img_data, conv_valid,
        output busy, done, w_addr, b_addr, img_addr, conv_rst,
               in_data, in_weight_1, in_weight_2, in_weight_3,
               in_bias, out_valid, out_row, out_col, err
    );

    modport slave (
        output start, w_data, b_data, img_data, conv_valid,
        input  busy, done, w_addr, b_addr, img_addr, conv_rst,
               in_data, in_weight_1, in_weight_2, in_weight_3,
               in_bias, out_valid, out_row, out_col, err
    );
endinterface

// File: rtl/conv_5ks_ctrl.sv
// Sequencer for the 5x5 three-channel convolution stage: loads weights,
// biases and pixels, then counts and tags output beats.
// Optional DRAIN watchdog: define CONV_CTRL_TIMEOUT_EN.
module conv_5ks_ctrl #(
    parameter int WIDTH    = 28,
    parameter int HEIGHT   = 28,
    parameter int KS       = 5,
    parameter int DATA_BIT = 8
) (
    input logic             clk,
    input logic             rst,
    conv_5ks_ctrl_if.master bus
);
    localparam int NW   = KS * KS;
    localparam int NB   = 3;
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int OW   = WIDTH - KS + 1;
    localparam int OH   = HEIGHT - KS + 1;
    localparam int NOUT = OW * OH;

    localparam logic [9:0] W_END = 10'(NW - 1);
    localparam logic [9:0] B_END = 10'(NB - 1);
    localparam logic [9:0] P_END = 10'(NPIX - 1);
    localparam logic [9:0] O_END = 10'(NOUT);
    localparam logic [4:0] C_END = 5'(OW - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD_W, LOAD_B, STREAM, DRAIN, DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        go;
    logic        phase_end;
    logic        busy_c;
    logic        done_c;
    logic [9:0]  cnt;
    logic        w_act;
    logic        b_act;
    logic        img_act;
    logic        w_act_d;
    logic        b_act_d;
    logic        img_act_d;
    logic        counting;
    logic        accept;
    logic [9:0]  out_cnt;
    logic [4:0]  row;
    logic [4:0]  col;
`ifdef CONV_CTRL_TIMEOUT_EN
    localparam logic [11:0] WD_MAX = 12'hFFF;
    logic [11:0] wd;
    logic        timeout;
    logic        err_q;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status decode for the load/stream/drain sequence.
    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        phase_end = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
`ifdef CONV_CTRL_TIMEOUT_EN
        timeout   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = LOAD_W;
                    go        = 1'b1;
                end
            end
            LOAD_W: begin
                busy_c = 1'b1;
                if (cnt == W_END) begin
                    state_nxt = LOAD_B;
                    phase_end = 1'b1;
                end
            end
            LOAD_B: begin
                busy_c = 1'b1;
                if (cnt == B_END) begin
                    state_nxt = STREAM;
                    phase_end = 1'b1;
                end
            end
            STREAM: begin
                busy_c = 1'b1;
                if (cnt == P_END) begin
                    state_nxt = DRAIN;
                    phase_end = 1'b1;
                end
            end
            DRAIN: begin
                busy_c = 1'b1;
                if (out_cnt == O_END) begin
                    state_nxt = DONE;
                end
`ifdef CONV_CTRL_TIMEOUT_EN
                else if (wd == WD_MAX && !bus.conv_valid) begin
                    state_nxt = DONE;
                    timeout   = 1'b1;
                end
`endif
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;

    // Shared address counter, restarted at each phase boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (go || phase_end) begin
            cnt <= '0;
        end else if (state == LOAD_W || state == LOAD_B ||
                     state == STREAM) begin
            cnt <= cnt + 10'd1;
        end
    end

    // Registered addresses plus phase flags tracking the read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.w_addr   <= '0;
            bus.b_addr   <= '0;
            bus.img_addr <= '0;
            w_act        <= 1'b0;
            b_act        <= 1'b0;
            img_act      <= 1'b0;
            w_act_d      <= 1'b0;
            b_act_d      <= 1'b0;
            img_act_d    <= 1'b0;
        end else begin
            bus.w_addr   <= (state == LOAD_W) ? cnt[4:0] : 5'd0;
            bus.b_addr   <= (state == LOAD_B) ? cnt[1:0] : 2'd0;
            bus.img_addr <= (state == STREAM) ? cnt : 10'd0;
            w_act        <= state == LOAD_W;
            b_act        <= state == LOAD_B;
            img_act      <= state == STREAM;
            w_act_d      <= w_act;
            b_act_d      <= b_act;
            img_act_d    <= img_act;
        end
    end

    // Read data registered once onto the datapath buses, zero off-phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.in_weight_1 <= '0;
            bus.in_weight_2 <= '0;
            bus.in_weight_3 <= '0;
            bus.in_bias     <= '0;
            bus.in_data     <= '0;
            bus.conv_rst    <= 1'b1;
        end else begin
            bus.in_weight_1 <= w_act_d ? bus.w_data[3:0] : 4'd0;
            bus.in_weight_2 <= w_act_d ? bus.w_data[7:4] : 4'd0;
            bus.in_weight_3 <= w_act_d ? bus.w_data[11:8] : 4'd0;
            bus.in_bias     <= b_act_d ? bus.b_data : 8'd0;
            bus.in_data     <= img_act_d ? bus.img_data
                                         : {DATA_BIT{1'b0}};
            if (state_nxt == IDLE) begin
                bus.conv_rst <= 1'b1;
            end else if (w_act_d) begin
                bus.conv_rst <= 1'b0;
            end
        end
    end

    assign counting = (state == STREAM) || (state == DRAIN);
    assign accept   = counting && bus.conv_valid && (out_cnt != O_END);

    // Output beat counter with raster row/column tagging.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt       <= '0;
            row           <= '0;
            col           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_row   <= '0;
            bus.out_col   <= '0;
        end else if (go) begin
            out_cnt       <= '0;
            row           <= '0;
            col           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_row   <= '0;
            bus.out_col   <= '0;
        end else begin
            bus.out_valid <= accept;
            bus.out_row   <= accept ? row : 5'd0;
            bus.out_col   <= accept ? col : 5'd0;
            if (accept) begin
                out_cnt <= out_cnt + 10'd1;
                if (col == C_END) begin
                    col <= '0;
                    row <= row + 5'd1;
                end else begin
                    col <= col + 5'd1;
                end
            end
        end
    end

`ifdef CONV_CTRL_TIMEOUT_EN
    // Watchdog on datapath silence; expiry ends the run with err set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd    <= '0;
            err_q <= 1'b0;
        end else if (go) begin
            wd    <= '0;
            err_q <= 1'b0;
        end else begin
            if (!counting || bus.conv_valid) begin
                wd <= '0;
            end else if (wd != WD_MAX) begin
                wd <= wd + 12'd1;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_conv_5ks_ctrl.sv
// Self-checking bench for conv_5ks_ctrl: ROM/RAM models, a datapath beat
// generator and a timeline reference model derived from phase lengths.
module tb_conv_5ks_ctrl;
    localparam int NW    = 25;
    localparam int NB    = 3;
    localparam int NPIX  = 784;
    localparam int OW    = 24;
    localparam int NOUT  = 576;
    localparam int W0    = 1;
    localparam int B0    = W0 + NW;
    localparam int P0    = B0 + NB;
    localparam int LAT   = 2;
    localparam int BEAT0 = 300;
    localparam int WD_T  = 4095;

    logic clk = 1'b0;
    logic rst;

    conv_5ks_ctrl_if #(.DATA_BIT(8)) bus ();

    conv_5ks_ctrl #(
        .WIDTH(28), .HEIGHT(28), .KS(5), .DATA_BIT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [11:0] wrom [32];
    logic [7:0]  brom [4];
    logic [7:0]  img  [1024];

    always @(posedge clk) begin
        bus.w_data   <= wrom[bus.w_addr];
        bus.b_data   <= brom[bus.b_addr];
        bus.img_data <= img[bus.img_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_win(input int t, input int base, input int len);
        return (t >= base) && (t < base + len);
    endfunction

    task automatic chk_idle(input string tag, input bit err_e);
        chk({tag, ".busy"},     32'(bus.busy), 0);
        chk({tag, ".done"},     32'(bus.done), 0);
        chk({tag, ".conv_rst"}, 32'(bus.conv_rst), 1);
        chk({tag, ".w_addr"},   32'(bus.w_addr), 0);
        chk({tag, ".b_addr"},   32'(bus.b_addr), 0);
        chk({tag, ".img_addr"}, 32'(bus.img_addr), 0);
        chk({tag, ".in_w1"},    32'(bus.in_weight_1), 0);
        chk({tag, ".in_w2"},    32'(bus.in_weight_2), 0);
        chk({tag, ".in_w3"},    32'(bus.in_weight_3), 0);
        chk({tag, ".in_bias"},  32'(bus.in_bias), 0);
        chk({tag, ".in_data"},  32'(bus.in_data), 0);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 0);
        chk({tag, ".err"},      32'(bus.err), 32'(err_e));
    endtask

    task automatic check_cycle(input int t, input int done_t, input bit ov,
                               input int r, input int c, input bit err_e);
        logic [11:0] w;
        bit          bz;
        w  = in_win(t, W0 + LAT, NW) ? wrom[t - W0 - LAT] : 12'd0;
        bz = (done_t < 0) || (t < done_t);
        chk("busy",     32'(bus.busy), 32'(bz));
        chk("done",     32'(bus.done), 32'(t == done_t));
        chk("w_addr",   32'(bus.w_addr), in_win(t, W0, NW) ? t - W0 : 0);
        chk("b_addr",   32'(bus.b_addr), in_win(t, B0, NB) ? t - B0 : 0);
        chk("img_addr", 32'(bus.img_addr),
            in_win(t, P0, NPIX) ? t - P0 : 0);
        chk("in_w1",    32'(bus.in_weight_1), 32'(w[3:0]));
        chk("in_w2",    32'(bus.in_weight_2), 32'(w[7:4]));
        chk("in_w3",    32'(bus.in_weight_3), 32'(w[11:8]));
        chk("in_bias",  32'(bus.in_bias),
            in_win(t, B0 + LAT, NB) ? 32'(brom[t - B0 - LAT]) : 0);
        chk("in_data",  32'(bus.in_data),
            in_win(t, P0 + LAT, NPIX) ? 32'(img[t - P0 - LAT]) : 0);
        chk("conv_rst", 32'(bus.conv_rst), 32'(t < W0 + LAT));
        chk("out_valid", 32'(bus.out_valid), 32'(ov));
        if (ov) begin
            chk("out_row", 32'(bus.out_row), r);
            chk("out_col", 32'(bus.out_col), c);
        end
        chk("err",      32'(bus.err), 32'(err_e));
    endtask

    task automatic run_img(input int nbeats, input bit gaps, input int max_t,
                           input int rp0, input int rp1, input bit exp_done);
        int n      = 0;
        int sent   = 0;
        int done_t = -1;
        int t_576  = -1;
        int t_last = -1;
        int r      = 0;
        int c      = 0;
        bit ov     = 1'b0;
        bit cv     = 1'b0;
        bit err_e  = 1'b0;
        bit fin    = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        for (int t = 0; t < max_t && !fin; t++) begin
            @(negedge clk);
            bus.start = (t == rp0) || (t == rp1);
            if (t_576 >= 0) done_t = t_576 + 1;
`ifdef CONV_CTRL_TIMEOUT_EN
            else if (t_last >= 0) done_t = t_last + WD_T;
            err_e = (t_576 < 0) && (done_t >= 0) && (t >= done_t);
`endif
            check_cycle(t, done_t, ov, r, c, err_e);
            fin = (t == done_t);
            cv = !fin && (t + 1 >= BEAT0) && (sent < nbeats) &&
                 (!gaps || ($urandom_range(0, 3) != 0));
            bus.conv_valid = cv;
            if (cv) begin
                sent++;
                t_last = t + 1;
            end
            ov = cv && (n < NOUT);
            if (ov) begin
                r = n / OW;
                c = n % OW;
                n++;
                if (n == NOUT) t_576 = t + 1;
            end
        end
        bus.conv_valid = 1'b0;
        bus.start      = 1'b0;
        chk("run_end", 32'(fin), 32'(exp_done));
        if (fin) begin
            @(negedge clk);
            chk_idle("post_done", err_e);
        end else begin
            rst = 1'b1;
            #1;
            chk_idle("reset_now", 1'b0);
            @(negedge clk);
            chk_idle("reset_hold", 1'b0);
            rst = 1'b0;
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.conv_valid = 1'b0;
        bus.w_data     = '0;
        bus.b_data     = '0;
        bus.img_data   = '0;
        for (int k = 0; k < 32; k++) wrom[k] = {k[3:0], k[3:0], k[3:0]};
        for (int k = 0; k < 4; k++) brom[k] = 8'($urandom);
        for (int k = 0; k < 1024; k++) img[k] = k[7:0];
        repeat (3) @(negedge clk);
        chk_idle("reset", 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("after_reset", 1'b0);

        run_img(576, 1'b0, 2000, -1, -1, 1'b1);
        repeat (3) @(negedge clk);

        for (int k = 0; k < 32; k++) wrom[k] = 12'($urandom);
        for (int k = 0; k < 4; k++) brom[k] = 8'($urandom);
        for (int k = 0; k < 1024; k++) img[k] = 8'($urandom);
        run_img(576, 1'b1, 2500, 26, 850, 1'b1);
        repeat (2) @(negedge clk);

        run_img(600, 1'b1, 2500, -1, -1, 1'b1);
        repeat (2) @(negedge clk);

`ifdef CONV_CTRL_TIMEOUT_EN
        run_img(100, 1'b1, 6000, -1, -1, 1'b1);
        run_img(576, 1'b1, 2500, -1, -1, 1'b1);
`else
        run_img(100, 1'b1, 5000, -1, -1, 1'b0);
`endif
        repeat (2) @(negedge clk);

        run_img(576, 1'b0, 2000, -1, -1, 1'b1);
        run_img(576, 1'b0, 2000, -1, -1, 1'b1);
        repeat (2) @(negedge clk);

        run_img(576, 1'b1, P0 + 301, -1, -1, 1'b0);
        @(negedge clk);
        chk_idle("after_abort", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
